// File: rtl/mod_memreq_arbiter.sv
// Round-robin arbiter sharing one line-transfer memory bus between fetch,
// load and store requesters; sequences request, write-beat and read-beat phases.
module mod_memreq_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int BEATS  = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      if_req,
   input  logic [ADDR_W-1:0]         if_addr,
   input  logic                      ld_req,
   input  logic [ADDR_W-1:0]         ld_addr,
   input  logic                      st_req,
   input  logic [ADDR_W-1:0]         st_addr,
   input  logic [DATA_W*BEATS-1:0]   st_wdata,
   output logic                      if_gnt,
   output logic                      ld_gnt,
   output logic                      st_gnt,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      if_rvalid,
   output logic                      ld_rvalid,
   output logic                      if_done,
   output logic                      ld_done,
   output logic                      st_done,
   output logic                      bus_req,
   output logic                      bus_we,
   output logic [ADDR_W-1:0]         bus_addr,
   input  logic                      bus_reqack,
   output logic [DATA_W-1:0]         bus_wdata,
   output logic                      bus_wvalid,
   input  logic                      bus_resp_valid,
   input  logic [DATA_W-1:0]         bus_resp_data,
   output logic                      bus_respack
);

   localparam int CNT_W  = $clog2(BEATS) + 1;
   localparam int LINE_W = DATA_W * BEATS;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WR_BEAT, S_RD_BEAT} state_t;
   typedef enum logic [1:0] {SRC_FETCH, SRC_LOAD, SRC_STORE, SRC_NONE} src_t;

   state_t              r_state;
   src_t                r_rr_ptr;
   src_t                r_owner;
   logic [CNT_W-1:0]    r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [LINE_W-1:0]   r_wline;
   logic                r_if_gnt;
   logic                r_ld_gnt;
   logic                r_st_gnt;

   logic [2:0]          w_reqs;
   logic [2:0]          w_sum;
   logic [1:0]          w_idx;
   logic                w_win_vld;
   src_t                w_win;
   logic                w_last;
   logic                w_rbeat;

   function automatic src_t next_src(input src_t s);
      case (s)
         SRC_FETCH: return SRC_LOAD;
         SRC_LOAD:  return SRC_STORE;
         default:   return SRC_FETCH;
      endcase
   endfunction

   assign w_reqs = {st_req, ld_req, if_req};

   // First asserted requester found walking forward from the round-robin pointer
   always_comb begin
      w_win_vld = 1'b0;
      w_win     = SRC_NONE;
      w_sum     = '0;
      w_idx     = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         w_sum = {1'b0, r_rr_ptr} + 3'(i);
         w_idx = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[1:0];
         if (!w_win_vld && w_reqs[w_idx]) begin
            w_win_vld = 1'b1;
            w_win     = src_t'(w_idx);
         end
      end
   end

   assign w_last = (r_cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_rr_ptr <= SRC_FETCH;
         r_owner  <= SRC_NONE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_we     <= 1'b0;
         r_wline  <= '0;
         r_if_gnt <= 1'b0;
         r_ld_gnt <= 1'b0;
         r_st_gnt <= 1'b0;
      end else begin
         r_if_gnt <= 1'b0;
         r_ld_gnt <= 1'b0;
         r_st_gnt <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_vld) begin
                  r_owner  <= w_win;
                  r_rr_ptr <= next_src(w_win);
                  r_cnt    <= '0;
                  r_state  <= S_REQ;
                  case (w_win)
                     SRC_FETCH: begin
                        r_addr   <= if_addr;
                        r_we     <= 1'b0;
                        r_if_gnt <= 1'b1;
                     end
                     SRC_LOAD: begin
                        r_addr   <= ld_addr;
                        r_we     <= 1'b0;
                        r_ld_gnt <= 1'b1;
                     end
                     default: begin
                        r_addr   <= st_addr;
                        r_we     <= 1'b1;
                        r_wline  <= st_wdata;
                        r_st_gnt <= 1'b1;
                     end
                  endcase
               end
            end
            S_REQ: begin
               if (bus_reqack) begin
                  r_state <= r_we ? S_WR_BEAT : S_RD_BEAT;
                  r_cnt   <= '0;
               end
            end
            S_WR_BEAT: begin
               // Beat 0 sits in the MSBs, so the line shifts up one beat per cycle
               r_wline <= r_wline << DATA_W;
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_owner <= SRC_NONE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_RD_BEAT: begin
               if (bus_resp_valid) begin
                  if (w_last) begin
                     r_state <= S_IDLE;
                     r_owner <= SRC_NONE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_rbeat     = (r_state == S_RD_BEAT) && bus_resp_valid;

   assign if_gnt      = r_if_gnt;
   assign ld_gnt      = r_ld_gnt;
   assign st_gnt      = r_st_gnt;
   assign bus_req     = (r_state == S_REQ);
   assign bus_we      = r_we;
   assign bus_addr    = r_addr;
   assign bus_wvalid  = (r_state == S_WR_BEAT);
   assign bus_wdata   = bus_wvalid ? r_wline[LINE_W-1 -: DATA_W] : '0;
   assign bus_respack = w_rbeat;
   assign rd_data     = w_rbeat ? bus_resp_data : '0;
   assign if_rvalid   = w_rbeat && (r_owner == SRC_FETCH);
   assign ld_rvalid   = w_rbeat && (r_owner == SRC_LOAD);
   assign if_done     = w_rbeat && w_last && (r_owner == SRC_FETCH);
   assign ld_done     = w_rbeat && w_last && (r_owner == SRC_LOAD);
   assign st_done     = bus_wvalid && w_last;

endmodule

// File: tb/tb_mod_memreq_arbiter.sv
// Scoreboard bench for mod_memreq_arbiter: stimulus queues expected bus/owner
// events, an independent negedge monitor pops and compares them as they appear.
module tb_mod_memreq_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int BEATS  = 8;

   logic                     clk = 1'b0;
   logic                     reset = 1'b0;
   logic                     if_req = 1'b0, ld_req = 1'b0, st_req = 1'b0;
   logic [ADDR_W-1:0]        if_addr = '0, ld_addr = '0, st_addr = '0;
   logic [DATA_W*BEATS-1:0]  st_wdata = '0;
   logic                     if_gnt, ld_gnt, st_gnt;
   logic [DATA_W-1:0]        rd_data;
   logic                     if_rvalid, ld_rvalid;
   logic                     if_done, ld_done, st_done;
   logic                     bus_req, bus_we;
   logic [ADDR_W-1:0]        bus_addr;
   logic                     bus_reqack = 1'b0;
   logic [DATA_W-1:0]        bus_wdata;
   logic                     bus_wvalid;
   logic                     bus_resp_valid = 1'b0;
   logic [DATA_W-1:0]        bus_resp_data = '0;
   logic                     bus_respack;

   mod_memreq_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr),
      .ld_req(ld_req), .ld_addr(ld_addr),
      .st_req(st_req), .st_addr(st_addr), .st_wdata(st_wdata),
      .if_gnt(if_gnt), .ld_gnt(ld_gnt), .st_gnt(st_gnt),
      .rd_data(rd_data), .if_rvalid(if_rvalid), .ld_rvalid(ld_rvalid),
      .if_done(if_done), .ld_done(ld_done), .st_done(st_done),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_reqack(bus_reqack), .bus_wdata(bus_wdata), .bus_wvalid(bus_wvalid),
      .bus_resp_valid(bus_resp_valid), .bus_resp_data(bus_resp_data),
      .bus_respack(bus_respack)
   );

   always #5 clk = ~clk;

   typedef enum logic [2:0] {EV_GNT, EV_BUSREQ, EV_WBEAT, EV_RBEAT, EV_DONE} ev_kind_t;
   typedef struct {
      ev_kind_t    kind;
      logic [1:0]  who;   // 0 fetch, 1 load, 2 store; for EV_BUSREQ it holds bus_we
      logic [63:0] data;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input ev_kind_t k, input logic [1:0] w, input logic [63:0] d);
      ev_t e;
      e.kind = k;
      e.who  = w;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic observe(input ev_kind_t k, input logic [1:0] w, input logic [63:0] d);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected event %s who=%0d data=%h: nothing expected", k.name(), w, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind !== k || e.who !== w || e.data !== d) begin
            errors++;
            $display("FAIL event order: got %s who=%0d data=%h expected %s who=%0d data=%h",
                     k.name(), w, d, e.kind.name(), e.who, e.data);
         end
      end
   endtask

   // Monitor: every output event the DUT presents is matched against the queue
   initial begin
      logic prev_req;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            if (|{if_gnt, ld_gnt, st_gnt, if_rvalid, ld_rvalid, if_done, ld_done, st_done})
               check("one-hot", 64'({($countones({if_gnt, ld_gnt, st_gnt}) <= 1),
                                     ($countones({if_rvalid, ld_rvalid}) <= 1),
                                     ($countones({if_done, ld_done, st_done}) <= 1)}), 64'd7);
            if (if_gnt) observe(EV_GNT, 2'd0, '0);
            if (ld_gnt) observe(EV_GNT, 2'd1, '0);
            if (st_gnt) observe(EV_GNT, 2'd2, '0);
            if (bus_req && !prev_req) observe(EV_BUSREQ, {1'b0, bus_we}, bus_addr);
            if (bus_wvalid) observe(EV_WBEAT, 2'd2, bus_wdata);
            if (if_rvalid) observe(EV_RBEAT, 2'd0, rd_data);
            if (ld_rvalid) observe(EV_RBEAT, 2'd1, rd_data);
            if (if_done) observe(EV_DONE, 2'd0, '0);
            if (ld_done) observe(EV_DONE, 2'd1, '0);
            if (st_done) observe(EV_DONE, 2'd2, '0);
         end
         prev_req = bus_req;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [1:0] who, input logic [63:0] addr, input logic we);
      push(EV_GNT, who, '0);
      push(EV_BUSREQ, {1'b0, we}, addr);
   endtask

   task automatic wait_bus_req();
      int n = 0;
      while (!bus_req && n < 20) begin
         cyc();
         n++;
      end
      check("bus_req within bound", 64'(bus_req), 64'd1);
   endtask

   // Called in a REQ cycle; returns in the first beat cycle
   task automatic ack_after(input int d);
      repeat (d) cyc();
      bus_reqack = 1'b1;
      cyc();
      bus_reqack = 1'b0;
   endtask

   task automatic read_beats(input logic [1:0] who, input logic [63:0] base,
                             input int gap, input int n);
      logic [63:0] d;
      for (int b = 0; b < n; b++) begin
         d = base + 64'((b + 1) * 17);
         bus_resp_valid = 1'b1;
         bus_resp_data  = d;
         push(EV_RBEAT, who, d);
         if (b == BEATS - 1) push(EV_DONE, who, '0);
         #1 check("respack on valid beat", 64'(bus_respack), 64'd1);
         cyc();
         bus_resp_valid = 1'b0;
         bus_resp_data  = 64'hBAD0_BAD0_BAD0_BAD0;
         if (b < BEATS - 1) begin
            for (int g = 0; g < gap; g++) begin
               #1 check("respack in gap", 64'(bus_respack), 64'd0);
               cyc();
            end
         end
      end
   endtask

   // At poke beat a fetch request and a stray response are injected mid-write
   task automatic write_beats(input logic [DATA_W*BEATS-1:0] line, input int poke);
      logic [DATA_W*BEATS-1:0] l;
      l = line;
      for (int b = 0; b < BEATS; b++) push(EV_WBEAT, 2'd2, l[DATA_W*BEATS-1-DATA_W*b -: DATA_W]);
      push(EV_DONE, 2'd2, '0);
      for (int b = 0; b < BEATS; b++) begin
         if (b == poke) begin
            if_req         = 1'b1;
            if_addr        = 64'h7777;
            bus_resp_valid = 1'b1;
            bus_resp_data  = 64'hDEAD;
            #1 check("stray resp not acked in write", 64'(bus_respack), 64'd0);
         end
         cyc();
         if (b == poke) begin
            if_req         = 1'b0;
            bus_resp_valid = 1'b0;
         end
      end
   endtask

   function automatic logic [DATA_W*BEATS-1:0] mkline(input logic [63:0] base);
      logic [DATA_W*BEATS-1:0] l;
      for (int b = 0; b < BEATS; b++) l[DATA_W*BEATS-1-DATA_W*b -: DATA_W] = base + 64'(b);
      return l;
   endfunction

   task automatic check_all_zero(input string name);
      check(name, 64'({if_gnt, ld_gnt, st_gnt, if_rvalid, ld_rvalid, if_done, ld_done, st_done,
                       bus_req, bus_we, bus_wvalid, bus_respack}), 64'd0);
      check({name, " data"}, bus_addr | rd_data | bus_wdata, 64'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] who;
      // Reset state
      reset = 1'b0;
      repeat (3) cyc();
      reset = 1'b1;
      check_all_zero("reset outputs");
      cyc();

      // Single fetch, ack two cycles after the request
      if_addr = 64'h1000;
      issue(2'd0, 64'h1000, 1'b0);
      if_req = 1'b1;
      cyc();
      if_req  = 1'b0;
      if_addr = 64'hFFFF;
      wait_bus_req();
      ack_after(1);
      read_beats(2'd0, 64'h0, 0, BEATS);
      cyc();

      // Single store, ack in cycle 3, with a dropped fetch request mid-write
      st_addr  = 64'h2000;
      st_wdata = mkline(64'hA0);
      issue(2'd2, 64'h2000, 1'b1);
      st_req = 1'b1;
      cyc();
      st_req   = 1'b0;
      st_addr  = 64'h9999;
      st_wdata = '1;
      ack_after(2);
      write_beats(mkline(64'hA0), 1);
      repeat (3) cyc();

      // Round robin with all three requests held
      if_addr  = 64'h100;
      ld_addr  = 64'h200;
      st_addr  = 64'h300;
      st_wdata = mkline(64'hB0);
      if_req = 1'b1;
      ld_req = 1'b1;
      st_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         who = 2'(k % 3);
         issue(who, 64'h100 * 64'(k % 3 + 1), who == 2'd2);
         wait_bus_req();
         ack_after(0);
         if (k == 4) begin
            if_req = 1'b0;
            ld_req = 1'b0;
            st_req = 1'b0;
         end
         if (who == 2'd2) write_beats(mkline(64'hB0), -1);
         else read_beats(who, 64'h1000 * 64'(k + 1), 0, BEATS);
      end
      repeat (2) cyc();

      // Load read with response gaps 1,0,0,1,0,0,...
      ld_addr = 64'h3000;
      issue(2'd1, 64'h3000, 1'b0);
      ld_req = 1'b1;
      wait_bus_req();
      ld_req = 1'b0;
      ack_after(0);
      read_beats(2'd1, 64'h300, 2, BEATS);
      repeat (2) cyc();

      // Reset after the third beat of a load read
      ld_addr = 64'h4000;
      issue(2'd1, 64'h4000, 1'b0);
      ld_req = 1'b1;
      wait_bus_req();
      ld_req = 1'b0;
      ack_after(0);
      read_beats(2'd1, 64'h400, 0, 3);
      reset = 1'b0;
      cyc();
      reset          = 1'b1;
      bus_resp_valid = 1'b1;
      bus_resp_data  = 64'h5555;
      bus_reqack     = 1'b1;
      #1 check_all_zero("outputs after mid-read reset");
      cyc();
      bus_resp_valid = 1'b0;
      bus_reqack     = 1'b0;
      cyc();

      // Pointer back at FETCH: load beats store in the next arbitration
      ld_addr  = 64'h5000;
      st_addr  = 64'h6000;
      st_wdata = mkline(64'hC0);
      issue(2'd1, 64'h5000, 1'b0);
      ld_req = 1'b1;
      st_req = 1'b1;
      wait_bus_req();
      ld_req = 1'b0;
      ack_after(0);
      read_beats(2'd1, 64'h500, 0, BEATS);
      issue(2'd2, 64'h6000, 1'b1);
      wait_bus_req();
      st_req = 1'b0;
      ack_after(1);
      write_beats(mkline(64'hC0), -1);
      repeat (4) cyc();

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
